// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp -- sequential digit-serial magnitude comparator.
//
// Compares two WIDTH-bit operands one DIGIT-bit digit per clock cycle,
// most-significant digit first, in either unsigned or two's-complement mode.
// With EARLY_EXIT=1 the compare stops at the first digit that decides the
// result; with EARLY_EXIT=0 it always walks all NDIG digits, giving a fixed
// latency.
//
// Parameters
//   WIDTH       operand width in bits (must be a positive multiple of DIGIT)
//   DIGIT       bits compared per cycle
//   EARLY_EXIT  1 = stop at first deciding digit, 0 = always run NDIG digits
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   request a compare (ignored while busy)
//   signed_mode  in   1 = two's-complement compare, 0 = unsigned
//   a, b         in   operands, captured together with start
//   busy         out  high while digits are being compared
//   done         out  one-cycle pulse, eq/gt/lt updated in this cycle
//   eq, gt, lt   out  result flags, held until the next done
// -----------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;
    logic [CW-1:0]    cnt_q;
    logic             eq_acc_q;
    logic             gt_acc_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic [IW-1:0]    base_s;
    logic [DIGIT-1:0] flip_s;
    logic [DIGIT-1:0] dig_a_s;
    logic [DIGIT-1:0] dig_b_s;
    logic             eq_acc_d;
    logic             gt_acc_d;
    logic             last_s;
    logic             exit_s;

    // Current digit selection and accumulator update for the RUN state.
    always_comb begin
        // Bit index of the top of digit k (MSB-first walk).
        base_s  = IW'(WIDTH - 1) - IW'(IW'(cnt_q) * IW'(DIGIT));
        // In signed mode the sign digit is made unsigned-comparable by
        // flipping its top bit (offset-binary view of the sign).
        flip_s  = '0;
        flip_s[DIGIT-1] = sm_q & (cnt_q == CW'(0));
        dig_a_s = a_q[base_s -: DIGIT] ^ flip_s;
        dig_b_s = b_q[base_s -: DIGIT] ^ flip_s;

        eq_acc_d = eq_acc_q;
        gt_acc_d = gt_acc_q;
        // Once a digit has differed, the result is frozen.
        if (eq_acc_q) begin
            if (dig_a_s > dig_b_s) begin
                eq_acc_d = 1'b0;
                gt_acc_d = 1'b1;
            end else if (dig_a_s < dig_b_s) begin
                eq_acc_d = 1'b0;
                gt_acc_d = 1'b0;
            end else begin
                eq_acc_d = eq_acc_q;
                gt_acc_d = gt_acc_q;
            end
        end else begin
            eq_acc_d = eq_acc_q;
            gt_acc_d = gt_acc_q;
        end

        last_s = (cnt_q == CW'(NDIG - 1));
        if (EARLY_EXIT != 0) begin
            exit_s = last_s | ~eq_acc_d;
        end else begin
            exit_s = last_s;
        end
    end

    // Control FSM with operand capture, digit counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sm_q     <= 1'b0;
            cnt_q    <= '0;
            eq_acc_q <= 1'b0;
            gt_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        sm_q     <= signed_mode;
                        cnt_q    <= '0;
                        eq_acc_q <= 1'b1;
                        gt_acc_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    eq_acc_q <= eq_acc_d;
                    gt_acc_q <= gt_acc_d;
                    if (exit_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        eq_q    <= eq_acc_d;
                        gt_q    <= gt_acc_d;
                        lt_q    <= ~eq_acc_d & ~gt_acc_d;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp -- self-checking bench for seq_mag_comp (WIDTH=8, DIGIT=2).
// Two instances share the stimulus: index 0 has EARLY_EXIT=1, index 1 has
// EARLY_EXIT=0. A behavioural model predicts busy/done/eq/gt/lt every cycle
// from plain signed/unsigned arithmetic and a first-differing-digit search.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   busy_v, done_v, eq_v, gt_v, lt_v;

    int errors = 0;
    int checks = 0;

    seq_mag_comp #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) u_ee1 (
        .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
        .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0])
    );

    seq_mag_comp #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) u_ee0 (
        .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
        .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1])
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int       m_cnt  [2];
    bit       m_done [2];
    bit [2:0] m_flags[2];   // {eq, gt, lt}
    bit [2:0] p_flags[2];

    // Index of the first differing digit, MSB first; N if operands equal.
    function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int k = 0; k < N; k++) begin
            if (((x >> (W - D - k * D)) & 8'h03) != ((y >> (W - D - k * D)) & 8'h03))
                return k;
        end
        return N;
    endfunction

    function automatic bit [2:0] expect_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
        int sx, sy;
        if (sm) begin
            sx = $signed(x);
            sy = $signed(y);
        end else begin
            sx = int'(x);
            sy = int'(y);
        end
        if (sx == sy) return 3'b100;
        else if (sx > sy) return 3'b010;
        else return 3'b001;
    endfunction

    // Model update at each edge, then a compare of all outputs 1 time unit later.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_cnt[i]   = 0;
                m_done[i]  = 1'b0;
                m_flags[i] = 3'b000;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_done[i]  = 1'b1;
                    m_flags[i] = p_flags[i];
                end
            end else begin
                m_done[i] = 1'b0;
                if (start) begin
                    int fd;
                    fd = first_diff(a, b);
                    p_flags[i] = expect_flags(a, b, signed_mode);
                    m_cnt[i] = (i == 0 && fd < N) ? fd + 1 : N;
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [4:0] got, exp;
            got = {busy_v[i], done_v[i], eq_v[i], gt_v[i], lt_v[i]};
            exp = {m_cnt[i] > 0, m_done[i], m_flags[i]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_model inst%0d t=%0t got busy,done,eq,gt,lt=%b expected %b",
                         i, $time, got, exp);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // One compare with hand-computed expectations: done sample edge and flags.
    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sm, input int exp_e0, input int exp_e1,
                            input bit [2:0] exp_f);
        int e0, e1;
        bit [2:0] f0, f1;
        e0 = 0; e1 = 0; f0 = 3'b000; f1 = 3'b000;
        @(negedge clock);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        @(posedge clock);                   // edge 0
        for (int e = 1; e <= 20 && (e0 == 0 || e1 == 0); e++) begin
            @(negedge clock);
            start = 1'b0;
            @(posedge clock);
            #2;
            if (e0 == 0 && done_v[0]) begin e0 = e + 1; f0 = {eq_v[0], gt_v[0], lt_v[0]}; end
            if (e1 == 0 && done_v[1]) begin e1 = e + 1; f1 = {eq_v[1], gt_v[1], lt_v[1]}; end
        end
        check({name, "_edge_ee1"}, e0, exp_e0);
        check({name, "_edge_ee0"}, e1, exp_e1);
        check({name, "_flags_ee1"}, int'(f0), int'(exp_f));
        check({name, "_flags_ee0"}, int'(f1), int'(exp_f));
    endtask

    // Single-cycle start, then bounded wait for the fixed-latency instance.
    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clock);
            if (done_v[1]) seen = 1'b1;
        end
        check("random_timeout", int'(seen), 1);
    endtask

    initial begin
        int cnt0, cnt1, first0, last0;
        reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs", int'({busy_v, done_v, eq_v, gt_v, lt_v}), 0);
        reset_n = 1'b1;

        // Unsigned equal: full run both instances.
        directed("eq_5a", 8'h5A, 8'h5A, 1'b0, 5, 5, 3'b100);
        // Signed: -128 < 127, decided on the sign digit.
        directed("s80_7f", 8'h80, 8'h7F, 1'b1, 2, 5, 3'b001);
        // Unsigned: 0x80 > 0x7F.
        directed("u80_7f", 8'h80, 8'h7F, 1'b0, 2, 5, 3'b010);
        // Difference only in the last digit.
        directed("late_41_42", 8'h41, 8'h42, 1'b0, 5, 5, 3'b001);
        // Early difference; fixed-latency instance still takes the full run.
        directed("c0_40", 8'hC0, 8'h40, 1'b0, 2, 5, 3'b010);
        // Signed negative vs negative: -1 > -2.
        directed("s_ff_fe", 8'hFF, 8'hFE, 1'b1, 5, 5, 3'b010);

        // Start while busy: second request ignored.
        @(negedge clock);
        a = 8'h10; b = 8'h20; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        a = 8'hF0; b = 8'h01; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("busy_start_flags_ee1", int'({eq_v[0], gt_v[0], lt_v[0]}), 1);
        check("busy_start_flags_ee0", int'({eq_v[1], gt_v[1], lt_v[1]}), 1);

        // Reset mid-run.
        @(negedge clock);
        a = 8'h33; b = 8'h34; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({busy_v, done_v, eq_v, gt_v, lt_v}), 0);
        cnt0 = 0;
        repeat (3) begin
            @(negedge clock);
            if (done_v != 2'b00) cnt0++;
        end
        check("reset_no_done", cnt0, 0);
        reset_n = 1'b1;
        directed("after_reset", 8'h33, 8'h34, 1'b0, 4, 5, 3'b001);

        // Back-to-back: start held for three accepts (edges 0, 5, 10).
        @(negedge clock);
        a = 8'h41; b = 8'h42; signed_mode = 1'b0; start = 1'b1;
        @(posedge clock);
        cnt0 = 0; cnt1 = 0; first0 = 0; last0 = 0;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clock);
            if (e == 11) start = 1'b0;
            @(posedge clock);
            #2;
            if (done_v[0]) begin
                cnt0++;
                if (first0 == 0) first0 = e;
                last0 = e;
            end
            if (done_v[1]) cnt1++;
        end
        check("b2b_pulses_ee1", cnt0, 3);
        check("b2b_pulses_ee0", cnt1, 3);
        check("b2b_first_edge", first0, 4);
        check("b2b_last_edge", last0, 14);

        // Randomised compares, biased towards shared leading digits.
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] x, y;
            int mode;
            x = W'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0: y = W'($urandom);
                1: y = x;
                2: y = x ^ (8'h01 << $urandom_range(0, W - 1));
                default: y = x ^ 8'h80;
            endcase
            go(x, y, 1'($urandom));
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
